// File: rtl/uart.sv
// uart: 8N1 serial receiver, two-flop rx synchronizer, mid-bit sampling.
// Define UART_FRAME_ERR_EN to add the frame_err output (bad stop bit pulse).
`timescale 1ns/100ps

// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | counting to the middle of the start bit to reject glitches
// DATA      | sampling 8 data bits, LSB first, one per bit period
// STOP      | sampling the stop bit; high publishes the byte
// WAIT_IDLE | bad stop bit or break; wait for the line to return high
module uart #(
    parameter int unsigned CLK_PER_BIT = 435
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
`ifdef UART_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int unsigned TW = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'((CLK_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] LAST = TW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state, state_nx;
    logic            rx_m, rx_s;
    logic [TW-1:0]   timer;
    logic [2:0]      index;
    logic [7:0]      shift;
    logic            tmr_clr, bit_smp, byte_ok;
`ifdef UART_FRAME_ERR_EN
    logic            frm_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tmr_clr  = 1'b0;
        bit_smp  = 1'b0;
        byte_ok  = 1'b0;
`ifdef UART_FRAME_ERR_EN
        frm_bad  = 1'b0;
`endif
        case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (!rx_s) state_nx = START;
            end
            START: begin
                // a start bit that is high again at its midpoint was a glitch
                if (timer == HALF) begin
                    tmr_clr  = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == LAST) begin
                    tmr_clr = 1'b1;
                    bit_smp = 1'b1;
                    if (index == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (timer == LAST) begin
                    tmr_clr = 1'b1;
                    if (rx_s) begin
                        byte_ok  = 1'b1;
                        state_nx = IDLE;
                    end else begin
`ifdef UART_FRAME_ERR_EN
                        frm_bad  = 1'b1;
`endif
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                tmr_clr = 1'b1;
                if (rx_s) state_nx = IDLE;
            end
            default: begin
                tmr_clr  = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            timer <= '0;
            index <= '0;
            shift <= '0;
            data  <= 8'h00;
            valid <= 1'b0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            timer <= tmr_clr ? '0 : timer + TW'(1);
            if (state == IDLE) begin
                index <= '0;
            end else if (bit_smp) begin
                shift[index] <= rx_s;
                index        <= index + 3'd1;
            end
            valid <= byte_ok;
            if (byte_ok) data <= shift;
        end
    end

`ifdef UART_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= frm_bad;
    end
`endif

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed serial frames against uart with a byte scoreboard.
// Builds with or without UART_FRAME_ERR_EN.
`timescale 1ns/100ps

module tb_uart;
    localparam int C   = 435;
    localparam int LAT = 3 + (C - 1) / 2 + 9 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
`ifdef UART_FRAME_ERR_EN
    logic       frame_err;
    int         n_ferr = 0;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_valid = 0;
    int         cyc     = 0;
    int         last_start = 0;
    logic       rst_q   = 1'b1;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_valid = 1'b0;
    logic [7:0] sb[$];

    uart #(.CLK_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid)
`ifdef UART_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #0.5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard pop and protocol checks on every output pulse
    always @(negedge clk) begin
        int lat;
        logic [7:0] exp_b;
        if (!rst_q) begin
            if (data !== prev_data) check("data_changes_only_with_valid", valid, 1'b1);
            if (valid === 1'b1) begin
                n_valid++;
                check("valid_one_cycle", prev_valid, 1'b0);
                check("valid_expected", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("rx_byte", data, exp_b);
                end
                lat = cyc - last_start;
                n_tests++;
                assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
                    n_fail++;
                    $error("FAIL latency: observed %0d cycles expected %0d +/-1", lat, LAT);
                end
            end
        end
        prev_data  = data;
        prev_valid = valid;
    end

`ifdef UART_FRAME_ERR_EN
    always @(negedge clk) if (frame_err === 1'b1) n_ferr++;
`endif

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input bit push);
        if (push) sb.push_back(b);
        rx = 1'b0;
        last_start = cyc + 1;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop_bit;
        repeat (C) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ab;
        ab = 8'h96;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
`ifdef UART_FRAME_ERR_EN
        check("reset_frame_err", frame_err, 1'b0);
`endif
        rst = 1'b0;
        idle(1000);

        send(8'h55, 1'b1, 1'b1);
        idle(C);
        check("count_after_55", n_valid, 1);

        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        idle(2 * C);
        check("count_after_b2b", n_valid, 3);
        check("data_after_b2b", data, 8'hFF);

        rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(2 * C);
        check("glitch_no_valid", n_valid, 3);
        send(8'hA5, 1'b1, 1'b1);
        idle(2 * C);
        check("count_after_a5", n_valid, 4);

        send(8'h3C, 1'b0, 1'b0);
        repeat (2000) @(negedge clk);
        idle(2 * C);
        check("bad_stop_no_valid", n_valid, 4);
        check("bad_stop_data_held", data, 8'hA5);
`ifdef UART_FRAME_ERR_EN
        check("frame_err_once", n_ferr, 1);
`endif
        send(8'hC3, 1'b1, 1'b1);
        idle(2 * C);
        check("count_after_c3", n_valid, 5);

        // 0x96 aborted in data bit 4; the transmitter shares the reset and goes idle
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = ab[i];
            repeat (C) @(negedge clk);
        end
        rx = ab[4];
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(6 * C);
        check("abort_no_valid", n_valid, 5);
        check("abort_data_cleared", data, 8'h00);

        send(8'h69, 1'b1, 1'b1);
        idle(2 * C);
        check("count_after_69", n_valid, 6);
        check("data_after_69", data, 8'h69);
        check("scoreboard_drained", sb.size(), 0);
`ifdef UART_FRAME_ERR_EN
        check("frame_err_total", n_ferr, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
